// File: rtl/lcd_bus_rx.sv
`timescale 1ns/1ps
// lcd_bus_rx: HD44780-style 4-bit LCD bus receiver with a 2x16 shadow display.
// Reassembles nibbles into bytes, executes the driver's instruction subset and
// stores data bytes at the cursor. Optional input synchronizer: LCD_BUS_RX_SYNC_EN.
module lcd_bus_rx #(
  parameter logic [7:0] INIT_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lcd_data,
  input  logic       lcd_en,
  input  logic       lcd_rw,
  input  logic       lcd_rs,
  input  logic       rd_row,
  input  logic [3:0] rd_pos,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       wr_valid,
  output logic [6:0] cursor,
  output logic       four_bit,
  output logic       two_line,
  output logic       display_on,
  output logic       proto_err
);

  localparam int unsigned CELLS  = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned STG_W  = 7;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   fill_cnt, fill_cnt_n;
  logic            busy_n;
  logic [6:0]      cursor_n;
  logic            inc, inc_n;
  logic            four_bit_n, two_line_n, display_on_n;
  logic            phase_lo, phase_lo_n;
  logic [3:0]      hi_nib, hi_nib_n;
  logic            hi_rs, hi_rs_n;
  logic            cmd_valid_n, wr_valid_n, proto_err_n;
  logic [7:0]      cmd_byte_n;

  logic            mem_we_c;
  logic [AW-1:0]   mem_addr_c;
  logic [7:0]      mem_wdata_c;
  logic [7:0]      mem [CELLS];

  logic            byte_ok_c;
  logic            byte_rs_c;
  logic [7:0]      byte_c;

  // Staged bus bits: {rw, rs, en, data}
  logic [STG_W-1:0] stg_c;
  logic [STG_W-1:0] stg_q;
  logic             fall_c;
  logic [3:0]       data_q;
  logic             rs_q, rw_q;

`ifdef LCD_BUS_RX_SYNC_EN
  logic [STG_W-1:0] sync1, sync2;

  // Two-flop synchronizer for an asynchronous driver
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {lcd_rw, lcd_rs, lcd_en, lcd_data};
      sync2 <= sync1;
    end
  end

  assign stg_c = sync2;
`else
  assign stg_c = {lcd_rw, lcd_rs, lcd_en, lcd_data};
`endif

  // Edge-detect register; also holds the bus values sampled before the fall
  always_ff @(posedge clk) begin
    if (rst) stg_q <= '0;
    else     stg_q <= stg_c;
  end

  assign fall_c = stg_q[4] & ~stg_c[4];
  assign data_q = stg_q[3:0];
  assign rs_q   = stg_q[5];
  assign rw_q   = stg_q[6];

  // Cursor step over the two visible 16-cell rows, wrapping row to row
  function automatic logic [6:0] cursor_step(input logic [6:0] c, input logic up);
    logic [6:0] r;
    if (up) begin
      case (c)
        7'h0F:   r = 7'h40;
        7'h4F:   r = 7'h00;
        default: r = c + 7'd1;
      endcase
    end else begin
      case (c)
        7'h40:   r = 7'h0F;
        7'h00:   r = 7'h4F;
        default: r = c - 7'd1;
      endcase
    end
    return r;
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      busy       <= 1'b1;
      cursor     <= '0;
      inc        <= 1'b1;
      four_bit   <= 1'b0;
      two_line   <= 1'b0;
      display_on <= 1'b0;
      phase_lo   <= 1'b0;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      wr_valid   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_n;
      fill_cnt   <= fill_cnt_n;
      busy       <= busy_n;
      cursor     <= cursor_n;
      inc        <= inc_n;
      four_bit   <= four_bit_n;
      two_line   <= two_line_n;
      display_on <= display_on_n;
      phase_lo   <= phase_lo_n;
      hi_nib     <= hi_nib_n;
      hi_rs      <= hi_rs_n;
      cmd_valid  <= cmd_valid_n;
      cmd_byte   <= cmd_byte_n;
      wr_valid   <= wr_valid_n;
      proto_err  <= proto_err_n;
    end
  end

  // Next-state: fill sequencing, nibble assembly, instruction/data execution
  always_comb begin
    state_n      = state;
    fill_cnt_n   = fill_cnt;
    cursor_n     = cursor;
    inc_n        = inc;
    four_bit_n   = four_bit;
    two_line_n   = two_line;
    display_on_n = display_on;
    phase_lo_n   = phase_lo;
    hi_nib_n     = hi_nib;
    hi_rs_n      = hi_rs;
    cmd_valid_n  = 1'b0;
    cmd_byte_n   = cmd_byte;
    wr_valid_n   = 1'b0;
    proto_err_n  = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    byte_ok_c    = 1'b0;
    byte_rs_c    = 1'b0;
    byte_c       = '0;

    case (state)
      FILL: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = fill_cnt;
        mem_wdata_c = INIT_CHAR;
        if (fill_cnt == LAST_CELL) state_n = IDLE;
        else                       fill_cnt_n = fill_cnt + AW'(1);
      end
      default: ;
    endcase

    if (fall_c) begin
      if (rw_q || busy) begin
        proto_err_n = 1'b1;
      end else if (!four_bit) begin
        byte_ok_c = 1'b1;
        byte_c    = {data_q, 4'b0000};
        byte_rs_c = rs_q;
      end else if (!phase_lo) begin
        hi_nib_n   = data_q;
        hi_rs_n    = rs_q;
        phase_lo_n = 1'b1;
      end else begin
        phase_lo_n = 1'b0;
        if (rs_q != hi_rs) begin
          proto_err_n = 1'b1;
        end else begin
          byte_ok_c = 1'b1;
          byte_c    = {hi_nib, data_q};
          byte_rs_c = rs_q;
        end
      end
    end

    if (byte_ok_c) begin
      if (!byte_rs_c) begin
        cmd_valid_n = 1'b1;
        cmd_byte_n  = byte_c;
        casez (byte_c)
          8'b1???????: cursor_n = byte_c[6:0];
          8'b01??????: begin end
          8'b001?????: begin
            four_bit_n = ~byte_c[4];
            two_line_n = byte_c[3];
          end
          8'b0001????: begin end
          8'b00001???: display_on_n = byte_c[2];
          8'b000001??: inc_n = byte_c[1];
          8'b0000001?: cursor_n = '0;
          8'b00000001: begin
            cursor_n   = '0;
            inc_n      = 1'b1;
            state_n    = FILL;
            fill_cnt_n = '0;
          end
          default: begin end
        endcase
      end else begin
        if (cursor[5:4] == 2'b00) begin
          mem_we_c    = 1'b1;
          mem_addr_c  = {cursor[6], cursor[3:0]};
          mem_wdata_c = byte_c;
          wr_valid_n  = 1'b1;
        end else begin
          proto_err_n = 1'b1;
        end
        cursor_n = cursor_step(cursor, inc);
      end
    end

    busy_n = (state_n == FILL);
  end

  // Shadow memory write port
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  // Registered read port; a same-cycle write returns the old cell value
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[{rd_row, rd_pos}];
  end

endmodule
